// File: rtl/enable_strobe_gen_pkg.sv
// Shared types and mode encodings for the enable strobe generator.
package enable_strobe_gen_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} strobe_state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/strobe_prescaler.sv
// Prescaler: counts p up to div_i and raises tick_o on the match cycle.
// p wraps to 0 after the match, clears on clr_i and holds while paused.
module strobe_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             s_rst_i,
  input  logic             clr_i,
  input  logic             run_i,
  input  logic             pause_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] p_q, p_d;
  logic             adv;

  assign adv    = run_i && !pause_i;
  assign tick_o = adv && (p_q == div_i);

  // Next prescaler value: clear, wrap on match, or increment while advancing
  always_comb begin
    p_d = p_q;
    if (clr_i)
      p_d = '0;
    else if (adv)
      p_d = (p_q == div_i) ? '0 : p_q + DIV_W'(1);
  end

  // Prescaler register
  always_ff @(posedge clk_i) begin
    if (s_rst_i) p_q <= '0;
    else         p_q <= p_d;
  end

endmodule

// File: rtl/enable_strobe_gen.sv
// Enable strobe generator: one-cycle enable every (divider+1) clocks,
// continuous or as a burst of N strobes followed by a done pulse.
// Optional pause input is compiled in with ENABLE_STROBE_GEN_PAUSE_EN.
module enable_strobe_gen
  import enable_strobe_gen_pkg::*;
#(
  parameter  int PRESCALE_MAX = 255,
  parameter  int BURST_MAX    = 1023,
  localparam int DIV_W        = $clog2(PRESCALE_MAX + 1),
  localparam int BST_W        = $clog2(BURST_MAX + 1)
) (
  input  logic             clk_i,
  input  logic             s_rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [DIV_W-1:0] divider_i,
  input  logic [BST_W-1:0] burst_len_i,
`ifdef ENABLE_STROBE_GEN_PAUSE_EN
  input  logic             pause_i,
`endif
  output logic             enable_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [BST_W-1:0] tick_count_o
);

  strobe_state_t    state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BST_W-1:0] len_q, len_d;
  logic [BST_W-1:0] tick_q, tick_d;
  logic             mode_q, mode_d;
  logic             clr, strobe, pause;

`ifdef ENABLE_STROBE_GEN_PAUSE_EN
  assign pause = pause_i;
`else
  assign pause = 1'b0;
`endif

  strobe_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk_i   (clk_i),
    .s_rst_i (s_rst_i),
    .clr_i   (clr),
    .run_i   (state_q == ST_RUN),
    .pause_i (pause),
    .div_i   (div_q),
    .tick_o  (strobe)
  );

  // Next-state, config latch and burst counter
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    len_d   = len_q;
    mode_d  = mode_q;
    tick_d  = tick_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          clr     = 1'b1;
          tick_d  = '0;
          mode_d  = mode_i;
          div_d   = (int'(divider_i) > PRESCALE_MAX) ? DIV_W'(PRESCALE_MAX) : divider_i;
          if (burst_len_i == '0)                 len_d = BST_W'(1);
          else if (int'(burst_len_i) > BURST_MAX) len_d = BST_W'(BURST_MAX);
          else                                   len_d = burst_len_i;
        end
      end
      ST_RUN: begin
        if (strobe) tick_d = tick_q + BST_W'(1);
        // stop beats completion, even on the final burst strobe
        if (stop_i)
          state_d = ST_IDLE;
        else if (mode_q == MODE_BURST && strobe && tick_d == len_q)
          state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, config and counter registers
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_CONT;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end

  assign enable_o     = strobe;
  assign busy_o       = (state_q == ST_RUN) || (state_q == ST_FINISH);
  assign done_o       = (state_q == ST_FINISH);
  assign tick_count_o = tick_q;

endmodule

// File: tb/tb_enable_strobe_gen.sv
// Directed self-checking bench for enable_strobe_gen.
// Cycle c=1 is the first cycle after the edge that accepted start.
module tb_enable_strobe_gen;

  logic       clk_i = 1'b0;
  logic       s_rst_i, start_i, stop_i, mode_i;
  logic [7:0] divider_i;
  logic [9:0] burst_len_i;
  logic       enable_o, busy_o, done_o;
  logic [9:0] tick_count_o;
`ifdef ENABLE_STROBE_GEN_PAUSE_EN
  logic       pause_i = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  enable_strobe_gen dut (
    .clk_i        (clk_i),
    .s_rst_i      (s_rst_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .mode_i       (mode_i),
    .divider_i    (divider_i),
    .burst_len_i  (burst_len_i),
`ifdef ENABLE_STROBE_GEN_PAUSE_EN
    .pause_i      (pause_i),
`endif
    .enable_o     (enable_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .tick_count_o (tick_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [7:0] d, input logic [9:0] l);
    start_i = 1'b1; mode_i = m; divider_i = d; burst_len_i = l;
    step();
    start_i = 1'b0; mode_i = ~m; divider_i = 8'h5A; burst_len_i = 10'h2A5;
  endtask

  task automatic test_reset();
    s_rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; mode_i = 1'b0;
    divider_i = '0; burst_len_i = '0;
    step(); step();
    checks++; if ({enable_o, busy_o, done_o} !== 3'b000) begin errors++; $display("FAIL reset_outs got=%b exp=000", {enable_o, busy_o, done_o}); end
    checks++; if (tick_count_o !== 10'd0) begin errors++; $display("FAIL reset_tick got=%0d exp=0", tick_count_o); end
    s_rst_i = 1'b0;
    step();
  endtask

  task automatic test_continuous();
    do_start(1'b0, 8'd3, 10'd0);
    for (int c = 1; c <= 16; c++) begin
      stop_i = (c == 13);
      checks++; if (enable_o !== (c <= 13 && c % 4 == 0)) begin errors++; $display("FAIL cont_en c=%0d got=%b exp=%b", c, enable_o, (c <= 13 && c % 4 == 0)); end
      checks++; if (busy_o !== (c <= 13)) begin errors++; $display("FAIL cont_busy c=%0d got=%b exp=%b", c, busy_o, (c <= 13)); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL cont_done c=%0d got=%b exp=0", c, done_o); end
      step();
    end
    stop_i = 1'b0;
    checks++; if (tick_count_o !== 10'd3) begin errors++; $display("FAIL cont_tick got=%0d exp=3", tick_count_o); end
  endtask

  task automatic test_burst();
    do_start(1'b1, 8'd0, 10'd5);
    for (int c = 1; c <= 8; c++) begin
      checks++; if (enable_o !== (c <= 5)) begin errors++; $display("FAIL burst_en c=%0d got=%b exp=%b", c, enable_o, (c <= 5)); end
      checks++; if (done_o !== (c == 6)) begin errors++; $display("FAIL burst_done c=%0d got=%b exp=%b", c, done_o, (c == 6)); end
      checks++; if (busy_o !== (c <= 6)) begin errors++; $display("FAIL burst_busy c=%0d got=%b exp=%b", c, busy_o, (c <= 6)); end
      if (c == 6) begin
        checks++; if (tick_count_o !== 10'd5) begin errors++; $display("FAIL burst_tick got=%0d exp=5", tick_count_o); end
      end
      step();
    end
  endtask

  task automatic test_len_zero();
    do_start(1'b1, 8'd2, 10'd0);
    for (int c = 1; c <= 6; c++) begin
      checks++; if (enable_o !== (c == 3)) begin errors++; $display("FAIL len0_en c=%0d got=%b exp=%b", c, enable_o, (c == 3)); end
      checks++; if (done_o !== (c == 4)) begin errors++; $display("FAIL len0_done c=%0d got=%b exp=%b", c, done_o, (c == 4)); end
      step();
    end
    checks++; if (tick_count_o !== 10'd1) begin errors++; $display("FAIL len0_tick got=%0d exp=1", tick_count_o); end
  endtask

  task automatic test_stop_last();
    do_start(1'b1, 8'd0, 10'd4);
    for (int c = 1; c <= 6; c++) begin
      stop_i = (c == 4);
      checks++; if (enable_o !== (c <= 4)) begin errors++; $display("FAIL stoplast_en c=%0d got=%b exp=%b", c, enable_o, (c <= 4)); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL stoplast_done c=%0d got=%b exp=0", c, done_o); end
      checks++; if (busy_o !== (c <= 4)) begin errors++; $display("FAIL stoplast_busy c=%0d got=%b exp=%b", c, busy_o, (c <= 4)); end
      step();
    end
    stop_i = 1'b0;
    checks++; if (tick_count_o !== 10'd4) begin errors++; $display("FAIL stoplast_tick got=%0d exp=4", tick_count_o); end
  endtask

  task automatic test_reset_mid();
    do_start(1'b1, 8'd0, 10'd8);
    step();                          // now c=2
    start_i = 1'b1; mode_i = 1'b0; divider_i = 8'd3; burst_len_i = 10'd1;
    step();                          // now c=3, restart must be ignored
    start_i = 1'b0;
    checks++; if (enable_o !== 1'b1) begin errors++; $display("FAIL midrst_div_kept got=%b exp=1", enable_o); end
    checks++; if (tick_count_o !== 10'd2) begin errors++; $display("FAIL midrst_tick2 got=%0d exp=2", tick_count_o); end
    s_rst_i = 1'b1;
    step();
    s_rst_i = 1'b0;
    checks++; if ({enable_o, busy_o, done_o} !== 3'b000) begin errors++; $display("FAIL midrst_outs got=%b exp=000", {enable_o, busy_o, done_o}); end
    checks++; if (tick_count_o !== 10'd0) begin errors++; $display("FAIL midrst_tick got=%0d exp=0", tick_count_o); end
    step();
    checks++; if ({enable_o, busy_o, done_o} !== 3'b000) begin errors++; $display("FAIL midrst_idle got=%b exp=000", {enable_o, busy_o, done_o}); end
  endtask

  task automatic test_start_busy();
    do_start(1'b1, 8'd0, 10'd3);
    for (int c = 1; c <= 5; c++) begin
      start_i = (c == 1); burst_len_i = 10'd1; divider_i = 8'd5;
      checks++; if (enable_o !== (c <= 3)) begin errors++; $display("FAIL busystart_en c=%0d got=%b exp=%b", c, enable_o, (c <= 3)); end
      checks++; if (done_o !== (c == 4)) begin errors++; $display("FAIL busystart_done c=%0d got=%b exp=%b", c, done_o, (c == 4)); end
      step();
    end
    start_i = 1'b0;
  endtask

  task automatic test_start_stop_idle();
    stop_i = 1'b1;
    do_start(1'b0, 8'd0, 10'd0);
    stop_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL startstop_busy got=%b exp=1", busy_o); end
    checks++; if (enable_o !== 1'b1) begin errors++; $display("FAIL startstop_en got=%b exp=1", enable_o); end
    stop_i = 1'b1; step(); stop_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL startstop_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_wrap();
    do_start(1'b0, 8'd0, 10'd0);
    for (int c = 1; c <= 1026; c++) begin
      if (c == 1025) begin
        checks++; if (tick_count_o !== 10'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", tick_count_o); end
        checks++; if (enable_o !== 1'b1) begin errors++; $display("FAIL wrap_en got=%b exp=1", enable_o); end
      end
      if (c == 1026) begin
        checks++; if (tick_count_o !== 10'd1) begin errors++; $display("FAIL wrap_one got=%0d exp=1", tick_count_o); end
      end
      step();
    end
    stop_i = 1'b1; step(); stop_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wrap_stop got=%b exp=0", busy_o); end
  endtask

`ifdef ENABLE_STROBE_GEN_PAUSE_EN
  task automatic test_pause();
    do_start(1'b0, 8'd3, 10'd0);
    for (int c = 1; c <= 12; c++) begin
      pause_i = (c >= 2 && c <= 4);
      checks++; if (enable_o !== (c == 7 || c == 11)) begin errors++; $display("FAIL pause_en c=%0d got=%b exp=%b", c, enable_o, (c == 7 || c == 11)); end
      if (c >= 2 && c <= 7) begin
        checks++; if (tick_count_o !== 10'd0) begin errors++; $display("FAIL pause_tick c=%0d got=%0d exp=0", c, tick_count_o); end
      end
      step();
    end
    pause_i = 1'b0;
    stop_i = 1'b1; step(); stop_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL pause_stop got=%b exp=0", busy_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    step();
    test_burst();
    test_len_zero();
    test_stop_last();
    test_reset_mid();
    test_start_busy();
    step();
    test_start_stop_idle();
    test_wrap();
`ifdef ENABLE_STROBE_GEN_PAUSE_EN
    test_pause();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
